// File: rtl/v850_fetch_pkg.sv
// Shared types and the instruction-length decode for the V850 fetch front end.
package v850_fetch_pkg;

    typedef logic [1:0] instr_len_t;

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } fetch_state_t;

    // Bits [15:5] of MOV imm32 with reg2 = r0: the only 48-bit form.
    localparam logic [10:0] MOV_IMM32_OP = 11'b00000110001;

    function automatic instr_len_t instr_len_hw(input logic [15:0] h);
        if (h[15:5] == MOV_IMM32_OP) begin
            return 2'd3;
        end
        if (h[10:9] == 2'b11) begin
            return 2'd2;
        end
        return 2'd1;
    endfunction

endpackage

// File: rtl/v850_fetch_queue_hw_queue.sv
// Circular halfword buffer: multi-push, multi-pop (up to 3) and flush; shows the head three halfwords.
module v850_hw_queue
    import v850_fetch_pkg::*;
#(
    parameter int HPF   = 2,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic [2:0]        push_n_i,
    input  logic [HPF*16-1:0] push_data_i,
    input  instr_len_t        pop_n_i,
    output logic [CW-1:0]     count_o,
    output logic [47:0]       head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < HPF; i++) begin
            if (3'(i) < push_n_i) begin
                mem_d[wr_ptr_q + AW'(i)] = push_data_i[i*16 +: 16];
            end
        end
        rd_ptr_d = rd_ptr_q + AW'(pop_n_i);
        wr_ptr_d = wr_ptr_q + AW'(push_n_i);
        count_d  = count_q + CW'(push_n_i) - CW'(pop_n_i);
        // Storage contents are left as-is on flush; only the pointers matter.
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        head_o = '0;
        for (int k = 0; k < 3; k++) begin
            if (CW'(k) < count_q) begin
                head_o[k*16 +: 16] = mem_q[rd_ptr_q + AW'(k)];
            end
        end
    end

    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/v850_fetch_queue.sv
// V850 instruction-fetch front end: credit-limited word fetches into a halfword queue,
// one 16/32/48-bit instruction per cycle to decode, redirect flush with stale-response drain.
module v850_fetch_queue
    import v850_fetch_pkg::*;
#(
    parameter int              FETCH_W   = 32,
    parameter int              QDEPTH_HW = 8,
    parameter int              MAX_OUTST = 2,
    parameter int              PC_W      = 25,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               mem_req_o,
    output logic [PC_W-1:0]    mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [FETCH_W-1:0] mem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [63:0]        instr_o,
    output logic [1:0]         instr_len_o,
    output logic [PC_W-1:0]    instr_pc_o
);
    localparam int HPF = FETCH_W / 16;
    localparam int AL  = $clog2(HPF);
    localparam int CW  = $clog2(QDEPTH_HW) + 1;
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(HPF - 1);

    fetch_state_t    state_q, state_d;
    logic [2:0]      outst_q, outst_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] head_pc_q, head_pc_d;
    logic [AL-1:0]   skip_q, skip_d;
    logic            req_q, req_d;

    logic [CW-1:0]      q_count, count_nxt;
    logic [47:0]        q_head;
    logic [2:0]         push_n;
    logic [FETCH_W-1:0] push_data;
    instr_len_t         head_len, pop_n;
    logic               push_en, valid, xfer, gnt_acc, credit_ok;

    v850_hw_queue #(
        .HPF   (HPF),
        .DEPTH (QDEPTH_HW),
        .CW    (CW)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_i),
        .push_n_i    (push_n),
        .push_data_i (push_data),
        .pop_n_i     (pop_n),
        .count_o     (q_count),
        .head_o      (q_head)
    );

    always_comb begin
        head_len  = instr_len_hw(q_head[15:0]);
        valid     = CW'(head_len) <= q_count;
        xfer      = valid && instr_ready_i;
        gnt_acc   = req_q && mem_gnt_i;
        // A response arriving with a redirect belongs to the old stream and is dropped.
        push_en   = mem_rvalid_i && (state_q == S_RUN) && !redirect_i;
        push_n    = push_en ? (3'(HPF) - 3'(skip_q)) : 3'd0;
        push_data = mem_rdata_i >> {skip_q, 4'b0000};
        pop_n     = xfer ? head_len : 2'd0;
        count_nxt = redirect_i ? '0 : (q_count + CW'(push_n) - CW'(pop_n));
        outst_d   = outst_q + 3'(gnt_acc) - 3'(mem_rvalid_i);

        state_d = state_q;
        if (redirect_i) begin
            state_d = (outst_d != 3'd0) ? S_DRAIN : S_RUN;
        end else if ((state_q == S_DRAIN) && (outst_d == 3'd0)) begin
            state_d = S_RUN;
        end

        // Reserve queue space for every response still owed plus the one being asked for.
        credit_ok = (int'(outst_d) < MAX_OUTST) &&
                    (int'(count_nxt) + (int'(outst_d) + 1) * HPF <= QDEPTH_HW);
        req_d = (state_d == S_RUN) && credit_ok;
        if (req_q && !mem_gnt_i && !redirect_i) begin
            req_d = 1'b1;
        end

        fetch_pc_d = fetch_pc_q;
        skip_d     = skip_q;
        head_pc_d  = head_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ALIGN_MASK;
            skip_d     = redirect_pc_i[AL-1:0];
            head_pc_d  = redirect_pc_i;
        end else begin
            if (gnt_acc) begin
                fetch_pc_d = fetch_pc_q + PC_W'(HPF);
            end
            if (push_en) begin
                skip_d = '0;
            end
            if (xfer) begin
                head_pc_d = head_pc_q + PC_W'(head_len);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            outst_q    <= '0;
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            skip_q     <= RESET_PC[AL-1:0];
            head_pc_q  <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            outst_q    <= outst_d;
            fetch_pc_q <= fetch_pc_d;
            skip_q     <= skip_d;
            head_pc_q  <= head_pc_d;
            req_q      <= req_d;
        end
    end

    assign mem_req_o     = req_q;
    assign mem_addr_o    = fetch_pc_q;
    assign instr_valid_o = valid;
    assign instr_len_o   = valid ? head_len : 2'd0;
    assign instr_pc_o    = valid ? head_pc_q : '0;
    assign instr_o       = valid ? {16'h0,
                                    (head_len == 2'd3) ? q_head[47:32] : 16'h0,
                                    (head_len != 2'd1) ? q_head[31:16] : 16'h0,
                                    q_head[15:0]} : 64'h0;

    assert property (@(posedge clk) disable iff (!rst_n) !(mem_rvalid_i && (outst_q == 3'd0)));
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push_en && (int'(q_count) + int'(push_n) - int'(pop_n) > QDEPTH_HW)));

endmodule

// File: tb/tb_v850_fetch_queue.sv
// Bench for v850_fetch_queue: a memory responder with random grant/latency and a
// program-order model of the instruction stream drawn from a halfword table.
module tb_v850_fetch_queue;
    localparam int FETCH_W   = 32;
    localparam int QDEPTH_HW = 8;
    localparam int MAX_OUTST = 2;
    localparam int PC_W      = 25;
    localparam int HPF       = FETCH_W / 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               redirect_i = 1'b0;
    logic [PC_W-1:0]    redirect_pc_i = '0;
    logic               mem_req_o;
    logic [PC_W-1:0]    mem_addr_o;
    logic               mem_gnt_i = 1'b0;
    logic               mem_rvalid_i = 1'b0;
    logic [FETCH_W-1:0] mem_rdata_i = '0;
    logic               instr_valid_o;
    logic               instr_ready_i = 1'b0;
    logic [63:0]        instr_o;
    logic [1:0]         instr_len_o;
    logic [PC_W-1:0]    instr_pc_o;

    v850_fetch_queue #(
        .FETCH_W   (FETCH_W),
        .QDEPTH_HW (QDEPTH_HW),
        .MAX_OUTST (MAX_OUTST),
        .PC_W      (PC_W),
        .RESET_PC  ('0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_len_o   (instr_len_o),
        .instr_pc_o    (instr_pc_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0]     tbl [256];
    logic [PC_W-1:0] pend_addr [$];
    int              pend_due [$];
    bit              gnt_rand = 1'b0;
    bit              rv_rand  = 1'b0;
    bit              rv_hold  = 1'b0;
    bit              prev_redir = 1'b0;
    logic [PC_W-1:0] exp_addr = '0;
    logic [PC_W-1:0] gen_pc = '0;
    // {pc[24:0], len[1:0], instr[63:0]}
    logic [90:0]     exp_q [$];
    logic [90:0]     acc_log [$];
    logic [PC_W-1:0] gnt_log [$];
    int              first_rv_cyc = -1;
    int              first_val_cyc = -1;

    function automatic logic [15:0] hw_at(input logic [PC_W-1:0] a);
        return tbl[a[7:0]];
    endfunction

    function automatic logic [90:0] model_instr(input logic [PC_W-1:0] pc);
        logic [15:0] h0, h1, h2;
        logic [1:0]  len;
        h0 = hw_at(pc);
        h1 = hw_at(pc + PC_W'(1));
        h2 = hw_at(pc + PC_W'(2));
        if (h0[15:5] == 11'b00000110001) len = 2'd3;
        else if (h0[10:9] == 2'b11)      len = 2'd2;
        else                              len = 2'd1;
        return {pc, len, 16'h0, (len == 2'd3) ? h2 : 16'h0, (len != 2'd1) ? h1 : 16'h0, h0};
    endfunction

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       h = {11'b00000110001, h[4:0]};
            1:       h[10:9] = 2'b11;
            default: h[10] = 1'b0;
        endcase
        return h;
    endfunction

    function automatic logic [90:0] acc_at(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 'x;
    endfunction

    function automatic logic [PC_W-1:0] gnt_at(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : 'x;
    endfunction

    // One clock: entered and left at a falling edge, with outputs stable.
    task automatic step(input bit redir, input logic [PC_W-1:0] tgt, input bit rdy);
        logic [90:0]     e;
        logic [90:0]     got;
        logic [PC_W-1:0] a;
        if (prev_redir) begin
            total++;
            if (instr_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL valid_after_redirect: got %b want 0", instr_valid_o);
            end
        end
        total++;
        if (pend_addr.size() > MAX_OUTST) begin
            bad++;
            $display("FAIL outstanding_limit: got %0d want <= %0d", pend_addr.size(), MAX_OUTST);
        end
        mem_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (!rv_hold && pend_addr.size() > 0 && pend_due[0] <= cyc &&
            (!rv_rand || $urandom_range(0, 2) == 0)) begin
            a = pend_addr.pop_front();
            void'(pend_due.pop_front());
            mem_rvalid_i = 1'b1;
            for (int i = 0; i < HPF; i++) mem_rdata_i[i*16 +: 16] = hw_at(a + PC_W'(i));
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
        end
        redirect_i    = redir;
        redirect_pc_i = tgt;
        instr_ready_i = rdy;
        if (mem_req_o && mem_gnt_i) begin
            total++;
            if (mem_addr_o !== exp_addr) begin
                bad++;
                $display("FAIL fetch_addr: got %h want %h", mem_addr_o, exp_addr);
            end
            gnt_log.push_back(mem_addr_o);
            pend_addr.push_back(mem_addr_o);
            pend_due.push_back(cyc + 1);
            exp_addr = exp_addr + PC_W'(HPF);
        end
        if (instr_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
        if (instr_valid_o && rdy) begin
            if (exp_q.size() == 0) begin
                e = model_instr(gen_pc);
                exp_q.push_back(e);
                gen_pc = gen_pc + PC_W'(e[65:64]);
            end
            e   = exp_q.pop_front();
            got = {instr_pc_o, instr_len_o, instr_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL instr: got pc=%h len=%0d instr=%h want pc=%h len=%0d instr=%h",
                         got[90:66], got[65:64], got[63:0], e[90:66], e[65:64], e[63:0]);
            end
            acc_log.push_back(got);
        end
        if (redir) begin
            exp_addr = tgt & ~PC_W'(HPF - 1);
            exp_q.delete();
            gen_pc = tgt;
        end
        prev_redir = redir;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_acc(input int n, input int budget, input int rdy_pct);
        int k = 0;
        while (acc_log.size() < n && k < budget) begin
            step(1'b0, '0, $urandom_range(0, 99) < rdy_pct);
            k++;
        end
        total++;
        if (acc_log.size() < n) begin
            bad++;
            $display("FAIL progress: got %0d accepted want %0d within %0d cycles", acc_log.size(), n, budget);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_len_o, instr_pc_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b addr=%h valid=%b instr=%h len=%0d pc=%h want all 0",
                     mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_len_o, instr_pc_o);
        end
    endtask

    task automatic test_basic();
        run_until_acc(2, 40, 100);
        total++;
        if (gnt_at(0) !== PC_W'(0) || gnt_at(1) !== PC_W'(2) || gnt_at(2) !== PC_W'(4)) begin
            bad++;
            $display("FAIL first_addrs: got %h %h %h want 0 2 4", gnt_at(0), gnt_at(1), gnt_at(2));
        end
        total++;
        if (acc_at(0) !== {PC_W'(0), 2'd1, 64'h1234}) begin
            bad++;
            $display("FAIL basic0: got %h want pc 0 len 1 instr 1234", acc_at(0));
        end
        total++;
        if (acc_at(1) !== {PC_W'(1), 2'd1, 64'h0}) begin
            bad++;
            $display("FAIL basic1: got %h want pc 1 len 1 instr 0", acc_at(1));
        end
        total++;
        if (first_val_cyc !== first_rv_cyc + 1) begin
            bad++;
            $display("FAIL first_valid_latency: got cycle %0d want %0d", first_val_cyc, first_rv_cyc + 1);
        end
    endtask

    task automatic test_straddle();
        int n0;
        step(1'b1, PC_W'('h40), 1'b1);
        n0 = acc_log.size();
        run_until_acc(n0 + 2, 40, 100);
        total++;
        if (acc_at(n0) !== {PC_W'('h40), 2'd1, 64'h0}) begin
            bad++;
            $display("FAIL straddle0: got %h want pc 40 len 1 instr 0", acc_at(n0));
        end
        total++;
        if (acc_at(n0 + 1) !== {PC_W'('h41), 2'd2, 64'hABCD07E0}) begin
            bad++;
            $display("FAIL straddle1: got %h want pc 41 len 2 instr abcd07e0", acc_at(n0 + 1));
        end
    endtask

    task automatic test_mov();
        int n0;
        logic [90:0] g;
        step(1'b1, PC_W'('h60), 1'b1);
        n0 = acc_log.size();
        run_until_acc(n0 + 2, 40, 60);
        total++;
        if (acc_at(n0) !== {PC_W'('h60), 2'd3, 64'h0000_1234_5678_0620}) begin
            bad++;
            $display("FAIL mov_imm32: got %h want pc 60 len 3 instr 123456780620", acc_at(n0));
        end
        g = acc_at(n0 + 1);
        total++;
        if (g[90:66] !== PC_W'('h63)) begin
            bad++;
            $display("FAIL mov_next_pc: got %h want 63", g[90:66]);
        end
    endtask

    task automatic test_redirect_drain();
        int k = 0;
        int n0;
        int g0;
        logic [90:0] g;
        rv_hold = 1'b1;
        while (pend_addr.size() < 2 && k < 40) begin
            step(1'b0, '0, 1'b1);
            k++;
        end
        total++;
        if (pend_addr.size() != 2) begin
            bad++;
            $display("FAIL two_outstanding: got %0d want 2", pend_addr.size());
        end
        step(1'b1, PC_W'('h13), 1'b1);
        g0 = gnt_log.size();
        n0 = acc_log.size();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (mem_req_o !== 1'b0) begin
                bad++;
                $display("FAIL drain_no_req: got %b want 0", mem_req_o);
            end
            step(1'b0, '0, 1'b1);
        end
        rv_hold = 1'b0;
        run_until_acc(n0 + 1, 40, 100);
        total++;
        if (gnt_at(g0) !== PC_W'('h12)) begin
            bad++;
            $display("FAIL drain_restart_addr: got %h want 12", gnt_at(g0));
        end
        g = acc_at(n0);
        total++;
        if (g[90:66] !== PC_W'('h13)) begin
            bad++;
            $display("FAIL drain_first_pc: got %h want 13", g[90:66]);
        end
    endtask

    task automatic test_backpressure();
        int g0;
        step(1'b1, PC_W'('h80), 1'b0);
        g0 = gnt_log.size();
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0);
        total++;
        if (gnt_log.size() - g0 != QDEPTH_HW / HPF) begin
            bad++;
            $display("FAIL backpressure_fetches: got %0d want %0d", gnt_log.size() - g0, QDEPTH_HW / HPF);
        end
        total++;
        if (mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_req: got %b want 0", mem_req_o);
        end
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);
        total++;
        if (gnt_log.size() - g0 <= QDEPTH_HW / HPF) begin
            bad++;
            $display("FAIL backpressure_resume: got %0d fetches want more than %0d", gnt_log.size() - g0, QDEPTH_HW / HPF);
        end
    endtask

    task automatic test_wrap();
        int n0;
        int g0;
        logic [90:0] g;
        step(1'b1, PC_W'('h1FFFFFE), 1'b1);
        g0 = gnt_log.size();
        n0 = acc_log.size();
        run_until_acc(n0 + 3, 60, 100);
        total++;
        if (gnt_at(g0) !== PC_W'('h1FFFFFE) || gnt_at(g0 + 1) !== PC_W'(0)) begin
            bad++;
            $display("FAIL wrap_addr: got %h %h want 1fffffe 0", gnt_at(g0), gnt_at(g0 + 1));
        end
        g = acc_at(n0 + 2);
        total++;
        if (g[90:66] !== PC_W'(0)) begin
            bad++;
            $display("FAIL wrap_pc: got %h want 0", g[90:66]);
        end
    endtask

    task automatic test_random();
        int n0;
        logic [PC_W-1:0] tgt;
        n0 = acc_log.size();
        gnt_rand = 1'b1;
        rv_rand  = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                tgt = ($urandom_range(0, 3) == 0) ? PC_W'(33554432 - $urandom_range(1, 6))
                                                  : PC_W'($urandom);
                step(1'b1, tgt, $urandom_range(0, 9) < 7);
            end else begin
                step(1'b0, '0, $urandom_range(0, 9) < 7);
            end
        end
        gnt_rand = 1'b0;
        rv_rand  = 1'b0;
        total++;
        if (acc_log.size() - n0 < 200) begin
            bad++;
            $display("FAIL random_throughput: got %0d instructions want >= 200", acc_log.size() - n0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = rand_hw();
        tbl[0] = 16'h1234;  tbl[1] = 16'h0000;  tbl[2] = 16'h5678;  tbl[3] = 16'h0000;
        tbl['h40] = 16'h0000; tbl['h41] = 16'h07E0; tbl['h42] = 16'hABCD; tbl['h43] = 16'h0001;
        tbl['h60] = 16'h0620; tbl['h61] = 16'h5678; tbl['h62] = 16'h1234; tbl['h63] = 16'h0001;
        tbl['hFE] = 16'h0001; tbl['hFF] = 16'h0002;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_straddle();
        test_mov();
        test_redirect_drain();
        test_backpressure();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
